// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared widths and scheduler state type for the trace block scheduler
package trace_pkg;

  localparam int BLOCK_ID_WIDTH    = 2;
  localparam int BUFFER_ADDR_WIDTH = 10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/block_id_fifo.sv
// rtl/block_id_fifo.sv - synchronous FIFO used for the free and occupied block pools
module block_id_fifo
  import trace_pkg::*;
#(
  parameter int Width = BLOCK_ID_WIDTH,
  parameter int Depth = 4,
  localparam int PtrWidth = $clog2(Depth),
  localparam int CountWidth = PtrWidth + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [Width-1:0]      push_data,
  input  logic                  pop,
  output logic [Width-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [CountWidth-1:0] count
);

  logic [Width-1:0]      mem [Depth];
  logic [PtrWidth-1:0]   wr_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic [CountWidth-1:0] count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CountWidth'(Depth));
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO is only honoured when a pop frees a slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PtrWidth'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PtrWidth'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CountWidth'(1);
        2'b01:   count_q <= count_q - CountWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/trace_block_scheduler.sv
// rtl/trace_block_scheduler.sv - hands trace buffer blocks to monitors and queues filled blocks for draining
module trace_block_scheduler
  import trace_pkg::*;
#(
  parameter int NumMonitors     = 2,
  parameter int NumBlocks       = 4,
  parameter int BufferAddrWidth = BUFFER_ADDR_WIDTH,
  parameter int BlockIdWidth    = BLOCK_ID_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NumMonitors-1:0]                 monitor_aquire_valid,
  output logic [NumMonitors-1:0]                 monitor_aquire_ready,
  output logic [NumMonitors*BlockIdWidth-1:0]    monitor_block_id,
  input  logic [NumMonitors-1:0]                 monitor_submit_valid,
  output logic [NumMonitors-1:0]                 monitor_submit_ready,
  input  logic [NumMonitors*BufferAddrWidth-1:0] monitor_submit_size,
  output logic                                   drain_valid,
  input  logic                                   drain_ready,
  output logic [BlockIdWidth-1:0]                drain_block_id,
  output logic [BufferAddrWidth-1:0]             drain_size,
  input  logic                                   release_valid,
  input  logic [BlockIdWidth-1:0]                release_block_id,
  output logic [BlockIdWidth:0]                  free_count,
  output logic                                   err_release
);

  localparam int PtrWidth   = (NumMonitors > 1) ? $clog2(NumMonitors) : 1;
  localparam int EntryWidth = BlockIdWidth + BufferAddrWidth;

  sched_state_t state, next_state;
  logic                              run;
  logic                              init_push;
  logic [BlockIdWidth-1:0]           init_cnt;

  logic [NumMonitors-1:0]            holding;
  logic [NumMonitors*BlockIdWidth-1:0] block_id_q;
  logic [NumBlocks-1:0]              outstanding;
  logic [PtrWidth-1:0]               aq_ptr;
  logic [PtrWidth-1:0]               sub_ptr;

  logic [NumMonitors-1:0]            aq_win;
  logic [NumMonitors-1:0]            sub_win;
  logic [NumMonitors-1:0]            aq_fire;
  logic [NumMonitors-1:0]            sub_fire;
  logic [EntryWidth-1:0]             sub_entry;

  logic                              rel_ok;
  logic                              rel_bad;
  logic                              drain_fire;

  logic                              free_push;
  logic [BlockIdWidth-1:0]           free_push_data;
  logic [BlockIdWidth-1:0]           free_head;
  logic                              free_empty;
  logic                              unused_free_full;

  logic                              occ_empty;
  logic                              unused_occ_full;
  logic [BlockIdWidth:0]             unused_occ_count;
  logic [EntryWidth-1:0]             occ_head;

  // Round-robin pick starting at ptr; returns a one-hot grant or zero.
  function automatic logic [NumMonitors-1:0] rr_onehot(input logic [NumMonitors-1:0] req,
                                                       input logic [PtrWidth-1:0]    ptr);
    logic [NumMonitors-1:0] g;
    int idx;
    g = '0;
    for (int k = 0; k < NumMonitors; k++) begin
      idx = (int'(ptr) + k) % NumMonitors;
      if (g == '0 && req[idx]) begin
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [PtrWidth-1:0] ptr_after(input logic [NumMonitors-1:0] g);
    logic [PtrWidth-1:0] p;
    p = '0;
    for (int i = 0; i < NumMonitors; i++) begin
      if (g[i]) begin
        p = (i == NumMonitors - 1) ? '0 : PtrWidth'(i + 1);
      end
    end
    return p;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + BlockIdWidth'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    init_push  = 1'b0;
    run        = 1'b0;
    case (state)
      ST_INIT: begin
        init_push = 1'b1;
        if (init_cnt == BlockIdWidth'(NumBlocks - 1)) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        run = 1'b1;
      end
      default: begin
        next_state = ST_INIT;
      end
    endcase
  end

  assign aq_win               = rr_onehot(monitor_aquire_valid & ~holding, aq_ptr);
  assign sub_win              = rr_onehot(monitor_submit_valid & holding, sub_ptr);
  assign monitor_aquire_ready = (run && !free_empty) ? aq_win : '0;
  assign monitor_submit_ready = run ? sub_win : '0;
  assign aq_fire              = monitor_aquire_valid & monitor_aquire_ready;
  assign sub_fire             = monitor_submit_valid & monitor_submit_ready;
  assign monitor_block_id     = block_id_q;

  always_comb begin
    sub_entry = '0;
    for (int i = 0; i < NumMonitors; i++) begin
      if (sub_fire[i]) begin
        sub_entry = {block_id_q[i*BlockIdWidth +: BlockIdWidth],
                     monitor_submit_size[i*BufferAddrWidth +: BufferAddrWidth]};
      end
    end
  end

  // Only blocks handed to the drain engine may come back; anything else is dropped and flagged.
  assign rel_ok  = release_valid & outstanding[release_block_id];
  assign rel_bad = release_valid & ~outstanding[release_block_id];

  assign drain_valid    = run & ~occ_empty;
  assign drain_fire     = drain_valid & drain_ready;
  assign drain_block_id = occ_head[EntryWidth-1:BufferAddrWidth];
  assign drain_size     = occ_head[BufferAddrWidth-1:0];

  assign free_push      = init_push | rel_ok;
  assign free_push_data = init_push ? init_cnt : release_block_id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holding     <= '0;
      block_id_q  <= '0;
      outstanding <= '0;
      aq_ptr      <= '0;
      sub_ptr     <= '0;
      err_release <= 1'b0;
    end else begin
      for (int i = 0; i < NumMonitors; i++) begin
        if (aq_fire[i]) begin
          holding[i]                                  <= 1'b1;
          block_id_q[i*BlockIdWidth +: BlockIdWidth] <= free_head;
        end else if (sub_fire[i]) begin
          holding[i] <= 1'b0;
        end
      end
      if (|aq_fire) begin
        aq_ptr <= ptr_after(aq_fire);
      end
      if (|sub_fire) begin
        sub_ptr <= ptr_after(sub_fire);
      end
      if (rel_ok) begin
        outstanding[release_block_id] <= 1'b0;
      end
      if (drain_fire) begin
        outstanding[drain_block_id] <= 1'b1;
      end
      if (rel_bad) begin
        err_release <= 1'b1;
      end
    end
  end

  block_id_fifo #(
    .Width (BlockIdWidth),
    .Depth (NumBlocks)
  ) u_free_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (free_push),
    .push_data (free_push_data),
    .pop       (|aq_fire),
    .pop_data  (free_head),
    .full      (unused_free_full),
    .empty     (free_empty),
    .count     (free_count)
  );

  block_id_fifo #(
    .Width (EntryWidth),
    .Depth (NumBlocks)
  ) u_occ_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (|sub_fire),
    .push_data (sub_entry),
    .pop       (drain_fire),
    .pop_data  (occ_head),
    .full      (unused_occ_full),
    .empty     (occ_empty),
    .count     (unused_occ_count)
  );

endmodule

// File: tb/tb_trace_block_scheduler.sv
// tb/tb_trace_block_scheduler.sv - directed self-checking bench for trace_block_scheduler
module tb_trace_block_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  aq_valid;
  logic [1:0]  aq_ready;
  logic [3:0]  monitor_block_id;
  logic [1:0]  sub_valid;
  logic [1:0]  sub_ready;
  logic [9:0]  size0;
  logic [9:0]  size1;
  logic        drain_valid;
  logic        drain_ready;
  logic [1:0]  drain_block_id;
  logic [9:0]  drain_size;
  logic        release_valid;
  logic [1:0]  release_block_id;
  logic [2:0]  free_count;
  logic        err_release;
  logic [1:0]  bid0;
  logic [1:0]  bid1;

  int n_vec = 0;
  int n_err = 0;

  assign bid0 = monitor_block_id[1:0];
  assign bid1 = monitor_block_id[3:2];

  always #5 clk = ~clk;

  trace_block_scheduler dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .monitor_aquire_valid (aq_valid),
    .monitor_aquire_ready (aq_ready),
    .monitor_block_id     (monitor_block_id),
    .monitor_submit_valid (sub_valid),
    .monitor_submit_ready (sub_ready),
    .monitor_submit_size  ({size1, size0}),
    .drain_valid          (drain_valid),
    .drain_ready          (drain_ready),
    .drain_block_id       (drain_block_id),
    .drain_size           (drain_size),
    .release_valid        (release_valid),
    .release_block_id     (release_block_id),
    .free_count           (free_count),
    .err_release          (err_release)
  );

  task automatic test_reset();
    reset_n = 1'b0; aq_valid = 2'b00; sub_valid = 2'b00; size0 = '0; size1 = '0;
    drain_ready = 1'b0; release_valid = 1'b0; release_block_id = '0;
    repeat (2) @(negedge clk);
    aq_valid = 2'b11;
    #1;
    n_vec++; if (free_count !== 3'd0) begin n_err++; $display("FAIL reset_free_count: got %0d expected 0", free_count); end
    n_vec++; if (aq_ready !== 2'b00) begin n_err++; $display("FAIL reset_aq_ready: got %b expected 00", aq_ready); end
    n_vec++; if (sub_ready !== 2'b00) begin n_err++; $display("FAIL reset_sub_ready: got %b expected 00", sub_ready); end
    n_vec++; if (drain_valid !== 1'b0) begin n_err++; $display("FAIL reset_drain_valid: got %b expected 0", drain_valid); end
    n_vec++; if (err_release !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err_release); end
    n_vec++; if (monitor_block_id !== 4'h0) begin n_err++; $display("FAIL reset_block_id: got %h expected 0", monitor_block_id); end
    reset_n = 1'b1;
  endtask

  task automatic test_init();
    logic [1:0] exp_rdy;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      exp_rdy = (k == 4) ? 2'b01 : 2'b00;
      n_vec++; if (free_count !== 3'(k)) begin n_err++; $display("FAIL init_free_count[%0d]: got %0d expected %0d", k, free_count, k); end
      n_vec++; if (aq_ready !== exp_rdy) begin n_err++; $display("FAIL init_aq_ready[%0d]: got %b expected %b", k, aq_ready, exp_rdy); end
    end
  endtask

  task automatic test_acquire_alternate();
    @(negedge clk); #1;
    n_vec++; if (aq_ready !== 2'b10) begin n_err++; $display("FAIL alt_second_grant: got %b expected 10", aq_ready); end
    n_vec++; if (bid0 !== 2'd0) begin n_err++; $display("FAIL alt_bid0: got %0d expected 0", bid0); end
    n_vec++; if (free_count !== 3'd3) begin n_err++; $display("FAIL alt_free3: got %0d expected 3", free_count); end
    @(negedge clk); #1;
    n_vec++; if (aq_ready !== 2'b00) begin n_err++; $display("FAIL alt_both_holding: got %b expected 00", aq_ready); end
    n_vec++; if (bid1 !== 2'd1) begin n_err++; $display("FAIL alt_bid1: got %0d expected 1", bid1); end
    n_vec++; if (free_count !== 3'd2) begin n_err++; $display("FAIL alt_free2: got %0d expected 2", free_count); end
    aq_valid = 2'b00;
  endtask

  task automatic test_submit_drain();
    @(negedge clk);
    sub_valid = 2'b01; size0 = 10'h123; drain_ready = 1'b0;
    #1;
    n_vec++; if (sub_ready !== 2'b01) begin n_err++; $display("FAIL sub_ready_m0: got %b expected 01", sub_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sub_valid = 2'b00;
      #1;
      n_vec++; if (drain_valid !== 1'b1) begin n_err++; $display("FAIL hold_drain_valid[%0d]: got %b expected 1", k, drain_valid); end
      n_vec++; if (drain_block_id !== 2'd0) begin n_err++; $display("FAIL hold_drain_id[%0d]: got %0d expected 0", k, drain_block_id); end
      n_vec++; if (drain_size !== 10'h123) begin n_err++; $display("FAIL hold_drain_size[%0d]: got %h expected 123", k, drain_size); end
    end
    @(negedge clk);
    drain_ready = 1'b1;
    @(negedge clk);
    drain_ready = 1'b0;
    #1;
    n_vec++; if (drain_valid !== 1'b0) begin n_err++; $display("FAIL drain_popped: got %b expected 0", drain_valid); end
    n_vec++; if (free_count !== 3'd2) begin n_err++; $display("FAIL drain_free_count: got %0d expected 2", free_count); end
  endtask

  task automatic test_concurrent();
    @(negedge clk);
    aq_valid = 2'b01; sub_valid = 2'b10; size1 = 10'h000;
    #1;
    n_vec++; if (aq_ready !== 2'b01) begin n_err++; $display("FAIL conc_aq_ready: got %b expected 01", aq_ready); end
    n_vec++; if (sub_ready !== 2'b10) begin n_err++; $display("FAIL conc_sub_ready: got %b expected 10", sub_ready); end
    @(negedge clk);
    aq_valid = 2'b00; sub_valid = 2'b00;
    #1;
    n_vec++; if (bid0 !== 2'd2) begin n_err++; $display("FAIL conc_bid0: got %0d expected 2", bid0); end
    n_vec++; if (bid1 !== 2'd1) begin n_err++; $display("FAIL conc_bid1_retained: got %0d expected 1", bid1); end
    n_vec++; if (free_count !== 3'd1) begin n_err++; $display("FAIL conc_free_count: got %0d expected 1", free_count); end
    n_vec++; if ({drain_valid, drain_block_id, drain_size} !== {1'b1, 2'd1, 10'h000}) begin
      n_err++; $display("FAIL conc_zero_size_drain: got %b/%0d/%h expected 1/1/000", drain_valid, drain_block_id, drain_size);
    end
    drain_ready = 1'b1;
    @(negedge clk);
    drain_ready = 1'b0;
  endtask

  task automatic test_full_pool();
    @(negedge clk);
    aq_valid = 2'b10;
    #1;
    n_vec++; if (aq_ready !== 2'b10) begin n_err++; $display("FAIL full_aq_m1: got %b expected 10", aq_ready); end
    @(negedge clk);
    aq_valid = 2'b00;
    #1;
    n_vec++; if (bid1 !== 2'd3) begin n_err++; $display("FAIL full_bid1: got %0d expected 3", bid1); end
    n_vec++; if (free_count !== 3'd0) begin n_err++; $display("FAIL full_free_empty: got %0d expected 0", free_count); end
    @(negedge clk);
    sub_valid = 2'b01; size0 = 10'h3ff;
    @(negedge clk);
    sub_valid = 2'b00; drain_ready = 1'b1;
    #1;
    n_vec++; if ({drain_valid, drain_block_id, drain_size} !== {1'b1, 2'd2, 10'h3ff}) begin
      n_err++; $display("FAIL full_drain_blk2: got %b/%0d/%h expected 1/2/3ff", drain_valid, drain_block_id, drain_size);
    end
    @(negedge clk);
    drain_ready = 1'b0; aq_valid = 2'b01; release_valid = 1'b1; release_block_id = 2'd2;
    #1;
    n_vec++; if (aq_ready !== 2'b00) begin n_err++; $display("FAIL full_no_bypass: got %b expected 00", aq_ready); end
    @(negedge clk);
    release_valid = 1'b0;
    #1;
    n_vec++; if (aq_ready !== 2'b01) begin n_err++; $display("FAIL full_grant_after_release: got %b expected 01", aq_ready); end
    n_vec++; if (free_count !== 3'd1) begin n_err++; $display("FAIL full_release_count: got %0d expected 1", free_count); end
    @(negedge clk);
    aq_valid = 2'b00;
    #1;
    n_vec++; if (bid0 !== 2'd2) begin n_err++; $display("FAIL full_bid0_blk2: got %0d expected 2", bid0); end
  endtask

  task automatic test_bad_release();
    @(negedge clk);
    release_valid = 1'b1; release_block_id = 2'd3;
    #1;
    n_vec++; if (err_release !== 1'b0) begin n_err++; $display("FAIL bad_rel_before: got %b expected 0", err_release); end
    @(negedge clk);
    release_valid = 1'b0;
    #1;
    n_vec++; if (err_release !== 1'b1) begin n_err++; $display("FAIL bad_rel_set: got %b expected 1", err_release); end
    n_vec++; if (free_count !== 3'd0) begin n_err++; $display("FAIL bad_rel_count: got %0d expected 0", free_count); end
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (err_release !== 1'b1) begin n_err++; $display("FAIL bad_rel_sticky: got %b expected 1", err_release); end
  endtask

  task automatic test_push_pop();
    @(negedge clk);
    release_valid = 1'b1; release_block_id = 2'd0;
    @(negedge clk);
    release_valid = 1'b0;
    #1;
    n_vec++; if (free_count !== 3'd1) begin n_err++; $display("FAIL pp_release0: got %0d expected 1", free_count); end
    @(negedge clk);
    sub_valid = 2'b10; size1 = 10'h055;
    #1;
    n_vec++; if (sub_ready !== 2'b10) begin n_err++; $display("FAIL pp_sub_m1: got %b expected 10", sub_ready); end
    @(negedge clk);
    sub_valid = 2'b00;
    #1;
    n_vec++; if ({drain_valid, drain_block_id, drain_size} !== {1'b1, 2'd3, 10'h055}) begin
      n_err++; $display("FAIL pp_drain_blk3: got %b/%0d/%h expected 1/3/055", drain_valid, drain_block_id, drain_size);
    end
    @(negedge clk);
    aq_valid = 2'b10; release_valid = 1'b1; release_block_id = 2'd1;
    #1;
    n_vec++; if (aq_ready !== 2'b10) begin n_err++; $display("FAIL pp_aq_m1: got %b expected 10", aq_ready); end
    @(negedge clk);
    aq_valid = 2'b00; release_valid = 1'b0;
    #1;
    n_vec++; if (bid1 !== 2'd0) begin n_err++; $display("FAIL pp_bid1: got %0d expected 0", bid1); end
    n_vec++; if (free_count !== 3'd1) begin n_err++; $display("FAIL pp_count_unchanged: got %0d expected 1", free_count); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    aq_valid = 2'b11;
    #1;
    n_vec++; if (drain_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_drain_valid: got %b expected 1", drain_valid); end
    #1;
    reset_n = 1'b0;
    #1;
    n_vec++; if (drain_valid !== 1'b0) begin n_err++; $display("FAIL mid_drain_valid: got %b expected 0", drain_valid); end
    n_vec++; if (free_count !== 3'd0) begin n_err++; $display("FAIL mid_free_count: got %0d expected 0", free_count); end
    n_vec++; if (err_release !== 1'b0) begin n_err++; $display("FAIL mid_err: got %b expected 0", err_release); end
    n_vec++; if (monitor_block_id !== 4'h0) begin n_err++; $display("FAIL mid_block_id: got %h expected 0", monitor_block_id); end
    n_vec++; if (aq_ready !== 2'b00) begin n_err++; $display("FAIL mid_aq_ready: got %b expected 00", aq_ready); end
    aq_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    aq_valid = 2'b01;
    #1;
    n_vec++; if (free_count !== 3'd4) begin n_err++; $display("FAIL mid_reinit_count: got %0d expected 4", free_count); end
    n_vec++; if (drain_valid !== 1'b0) begin n_err++; $display("FAIL mid_occ_discarded: got %b expected 0", drain_valid); end
    n_vec++; if (aq_ready !== 2'b01) begin n_err++; $display("FAIL mid_aq_after: got %b expected 01", aq_ready); end
    @(negedge clk);
    aq_valid = 2'b00;
    #1;
    n_vec++; if (bid0 !== 2'd0) begin n_err++; $display("FAIL mid_bid0_block0: got %0d expected 0", bid0); end
    n_vec++; if (free_count !== 3'd3) begin n_err++; $display("FAIL mid_free3: got %0d expected 3", free_count); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_acquire_alternate();
    test_submit_drain();
    test_concurrent();
    test_full_pool();
    test_bad_release();
    test_push_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trace_block_scheduler.md
TRACE_BLOCK_SCHEDULER -- requirements
Module: trace_block_scheduler

Interface
REQ-001 SHALL have parameter NumMonitors, default 2, number of monitors sharing the trace buffer.
REQ-002 SHALL have parameter NumBlocks, default 4, number of blocks the trace buffer is split into (power of two, >=2).
REQ-003 SHALL have parameter BufferAddrWidth, default 10, width of a block fill size.
REQ-004 SHALL have parameter BlockIdWidth, default 2, equal to log2(NumBlocks).
REQ-005 SHALL have ports (name  direction  width  meaning):
  clk  in  1  the single clock, rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  monitor_aquire_valid  in  NumMonitors  per-monitor free-block request.
  monitor_aquire_ready  out  NumMonitors  per-monitor grant.
  monitor_block_id  out  NumMonitors*BlockIdWidth  block currently owned by each monitor, slice i = monitor i.
  monitor_submit_valid  in  NumMonitors  per-monitor filled-block submit.
  monitor_submit_ready  out  NumMonitors  per-monitor submit accept.
  monitor_submit_size  in  NumMonitors*BufferAddrWidth  entries written, slice i = monitor i.
  drain_valid  out  1  filled block available to the drain engine.
  drain_ready  in  1  drain engine accepts the block.
  drain_block_id  out  BlockIdWidth  block to drain.
  drain_size  out  BufferAddrWidth  fill size of that block.
  release_valid  in  1  drain engine returns a drained block.
  release_block_id  in  BlockIdWidth  block being returned.
  free_count  out  BlockIdWidth+1  blocks in free pool.
  err_release  out  1  sticky illegal-release flag.

Function
REQ-006 SHALL run an FSM with states INIT and RUN; reset enters INIT.
REQ-007 INIT SHALL push block ids 0..NumBlocks-1 into the free FIFO, one per cycle, then enter RUN (NumBlocks cycles after reset release); all readies and drain_valid SHALL be 0 in INIT.
REQ-008 SHALL keep per-monitor holding[i] bit; monitor_aquire_ready[i] = RUN & !holding[i] & free FIFO non-empty & i is acquire-arbiter winner.
REQ-009 Acquire arbitration SHALL be round-robin among requesting non-holding monitors, one grant per cycle, priority pointer advancing to winner+1 after each handshake.
REQ-010 On acquire handshake SHALL pop free FIFO head, register it into monitor_block_id slice i and set holding[i]; new id visible the cycle after the handshake.
REQ-011 monitor_submit_ready[i] = RUN & holding[i] & i is submit-arbiter winner (separate round-robin, one submit per cycle).
REQ-012 On submit handshake SHALL push {monitor_block_id[i], monitor_submit_size[i]} into the occupied FIFO (depth NumBlocks, cannot overflow) and clear holding[i]; monitor_block_id slice retains last value.
REQ-013 A monitor may acquire and submit in different cycles only; a submit by monitor i and acquire by monitor j!=i in the same cycle SHALL both complete.
REQ-014 drain_valid SHALL equal occupied FIFO non-empty; drain_block_id/drain_size SHALL be its head, stable while drain_valid & !drain_ready; pop on handshake.
REQ-015 SHALL keep outstanding bitmap: set on drain handshake, cleared on release.
REQ-016 release_valid with outstanding[release_block_id]=1 SHALL push id into free FIFO next edge; otherwise SHALL drop it and set err_release until reset.
REQ-017 Free FIFO empty with simultaneous release: no bypass; the grant SHALL occur the following cycle at earliest.
REQ-018 Free FIFO pop and push in the same cycle SHALL both take effect; free_count unchanged.
REQ-019 free_count SHALL be the registered free FIFO occupancy (NumBlocks on entering RUN).
REQ-020 Size 0 submits SHALL be forwarded to the drain unchanged.

Reset
REQ-021 On reset_n low, asynchronously: state INIT, FIFOs empty, holding, outstanding, arbiter pointers, monitor_block_id, err_release, free_count all 0; all readies and drain_valid 0.
REQ-022 Reset mid-operation SHALL discard all ownership and occupied entries; recovery via INIT only.

Structure
REQ-023 Shared package trace_pkg SHALL hold BlockIdWidth/BufferAddrWidth defaults and the INIT/RUN state type.
REQ-024 One sub-module block_id_fifo (synchronous FIFO, parameter width/depth, push/pop/full/empty/count), instanced for free and occupied pools.

Verification
REQ-025 Reset release -> free_count 0,1,2,3,4 over 4 cycles, readies 0 until RUN.
REQ-026 Both monitors request every cycle -> grants alternate 0,1; monitor 0 gets block 0, monitor 1 block 1.
REQ-027 Monitor 0 submits size 0x123 on block 0, drain_ready held 0 for 3 cycles -> drain_valid=1, id 0, size 0x123 stable, then popped.
REQ-028 All 4 blocks held/occupied, monitor requests -> ready 0; release block 2 -> grant next cycle with id 2.
REQ-029 Release of block 3 never drained -> err_release=1 sticky, free_count unchanged.
REQ-030 Assert reset_n low mid-drain -> outputs zero immediately; INIT reruns, free_count returns to 4.
